// File: rtl/busca_instrucao_pkg.sv
// Shared RISC-V definitions: opcodes, instruction classes, fetch error codes
// and fetch-stage states.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    TIPO_R       = 3'd0,
    TIPO_I       = 3'd1,
    TIPO_S       = 3'd2,
    TIPO_SB      = 3'd3,
    TIPO_U       = 3'd4,
    TIPO_UJ      = 3'd5,
    TIPO_INVALID = 3'd7
  } tipo_op_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_TIMEOUT    = 2'b10
  } fetch_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory bus: request/address out, data/valid strobe back.
interface busca_instrucao_if;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_addr, output imem_req,
                  input  imem_rdata, input imem_valid);
  modport slave  (input  imem_addr, input imem_req,
                  output imem_rdata, output imem_valid);
endinterface

// File: rtl/busca_instrucao_decodifica_tipo.sv
// Combinational opcode/funct3 to instruction-class decode, shared with the
// control FSM.
module decodifica_tipo
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output tipo_op_t   tipo
);

  always_comb begin
    tipo = TIPO_INVALID;
    case (opcode)
      OP_R:                   tipo = TIPO_R;
      OP_IMM, OP_LOAD, OP_SYS: tipo = TIPO_I;
      OP_STORE:               tipo = TIPO_S;
      OP_BRANCH:              tipo = TIPO_SB;
      OP_JALR:                tipo = (funct3 == 3'b001) ? TIPO_SB : TIPO_I;
      OP_LUI:                 tipo = TIPO_U;
      OP_JAL:                 tipo = TIPO_UJ;
      default:                tipo = TIPO_INVALID;
    endcase
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: one request per accepted fetch_req, instruction
// register plus registered class, with misalign/timeout/flush handling.
module busca_instrucao
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] RESET_IR = NOP_INSTR
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     fetch_req,
  input  logic                     flush,
  input  logic [63:0]              pc_in,
  busca_instrucao_if.master        imem,
  output logic [31:0]              INSTRUCAO,
  output logic [6:0]               op_code,
  output tipo_op_t                 tipo_op,
  output logic                     fetch_done,
  output logic                     busy,
  output fetch_err_t               fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  tipo_op_t     tipo_q, tipo_d;
  fetch_err_t   err_q, err_d;
  logic [63:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tipo_op_t     rdata_tipo;

  decodifica_tipo u_decodifica_tipo (
    .opcode (imem.imem_rdata[6:0]),
    .funct3 (imem.imem_rdata[14:12]),
    .tipo   (rdata_tipo)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    tipo_d  = tipo_q;
    err_d   = err_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !flush) begin
          if (pc_in[1:0] != 2'b00) begin
            instr_d = RESET_IR;
            tipo_d  = TIPO_I;
            err_d   = ERR_MISALIGNED;
            done_d  = 1'b1;
          end else begin
            addr_d  = pc_in;
            req_d   = 1'b1;
            cnt_d   = '0;
            err_d   = ERR_OK;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // flush outranks both a same-cycle response and the timeout
        if (flush) begin
          state_d = imem.imem_valid ? ST_IDLE : ST_DRAIN;
        end else if (imem.imem_valid) begin
          instr_d = imem.imem_rdata;
          tipo_d  = rdata_tipo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          instr_d = RESET_IR;
          tipo_d  = TIPO_I;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (imem.imem_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      instr_q <= RESET_IR;
      tipo_q  <= TIPO_I;
      err_q   <= ERR_OK;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tipo_q  <= tipo_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign imem.imem_addr = addr_q;
  assign imem.imem_req  = req_q;
  assign INSTRUCAO      = instr_q;
  assign op_code        = instr_q[6:0];
  assign tipo_op        = tipo_q;
  assign fetch_done     = done_q;
  assign busy           = busy_q;
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed plus randomized fetch transactions checked against a
// transaction-level model of the fetch stage.
module tb_busca_instrucao;
  import riscv_pkg::*;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_req, flush;
  logic [63:0] pc_in;
  logic [31:0] INSTRUCAO;
  logic [6:0]  op_code;
  tipo_op_t    tipo_op;
  logic        fetch_done, busy;
  fetch_err_t  fetch_err;

  busca_instrucao_if bus ();

  busca_instrucao #(.TIMEOUT(TMO), .RESET_IR(32'h00000013)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .pc_in      (pc_in),
    .imem       (bus.master),
    .INSTRUCAO  (INSTRUCAO),
    .op_code    (op_code),
    .tipo_op    (tipo_op),
    .fetch_done (fetch_done),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: what the architectural registers must hold
  logic [31:0] m_instr;
  logic [2:0]  m_tipo;
  logic [1:0]  m_err;

  function automatic logic [2:0] ref_class(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'b0110011) return 3'd0;
    if (op inside {7'b0010011, 7'b0000011, 7'b1110011}) return 3'd1;
    if (op == 7'b0100011) return 3'd2;
    if (op == 7'b1100011) return 3'd3;
    if (op == 7'b1100111) return (w[14:12] == 3'b001) ? 3'd3 : 3'd1;
    if (op == 7'b0110111) return 3'd4;
    if (op == 7'b1101111) return 3'd5;
    return 3'd7;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_instr"}, 64'(INSTRUCAO), 64'(m_instr));
    chk({tag, "_op"},    64'(op_code),   64'(m_instr[6:0]));
    chk({tag, "_tipo"},  64'(tipo_op),   64'(m_tipo));
    chk({tag, "_err"},   64'(fetch_err), 64'(m_err));
  endtask

  task automatic model_reset();
    m_instr = 32'h00000013;
    m_tipo  = 3'd1;
    m_err   = 2'b00;
  endtask

  // One fetch transaction; memory answers in cycle lat (cycle 0 = the cycle
  // after the accepting edge); flush_at<0 means no flush.
  task automatic fetch(input string tag, input logic [63:0] pc, input logic [31:0] word,
                       input int lat, input int flush_at, input bit hold_req);
    int  done_cycle;
    bit  flushed;
    logic [31:0] r;
    pc_in     = pc;
    fetch_req = 1'b1;
    step();
    if (!hold_req) fetch_req = 1'b0;
    if (pc[1:0] != 2'b00) begin
      m_instr = 32'h00000013; m_tipo = 3'd1; m_err = 2'b01;
      chk({tag, "_mis_req"},  64'(bus.imem_req), 64'(0));
      chk({tag, "_mis_done"}, 64'(fetch_done),   64'(1));
      chk({tag, "_mis_busy"}, 64'(busy),         64'(0));
      check_regs({tag, "_mis"});
      fetch_req = 1'b0;
      step();
      chk({tag, "_mis_done_end"}, 64'(fetch_done), 64'(0));
      return;
    end
    m_err = 2'b00;
    flushed = (flush_at >= 0) && (flush_at <= lat) && (flush_at <= TMO);
    if (flushed)         done_cycle = -1;
    else if (lat <= TMO) done_cycle = lat + 1;
    else                 done_cycle = TMO + 1;
    chk({tag, "_req"},   64'(bus.imem_req), 64'(1));
    chk({tag, "_addr"},  bus.imem_addr,     pc);
    chk({tag, "_busy0"}, 64'(busy),         64'(1));
    chk({tag, "_done0"}, 64'(fetch_done),   64'(0));
    check_regs({tag, "_c0"});
    for (int c = 0; c <= lat; c++) begin
      r = $urandom();
      bus.imem_valid = (c == lat);
      bus.imem_rdata = (c == lat) ? word : r;
      flush          = (c == flush_at);
      step();
      bus.imem_valid = 1'b0;
      flush          = 1'b0;
      if (c == lat) fetch_req = 1'b0;
      if (c + 1 == done_cycle) begin
        if (lat <= TMO) begin
          m_instr = word; m_tipo = ref_class(word); m_err = 2'b00;
        end else begin
          m_instr = 32'h00000013; m_tipo = 3'd1; m_err = 2'b10;
        end
      end
      chk({tag, "_done"}, 64'(fetch_done),   64'(c + 1 == done_cycle));
      chk({tag, "_busy"}, 64'(busy),         64'(c + 1 <= lat));
      chk({tag, "_noreq"}, 64'(bus.imem_req), 64'(0));
      check_regs(tag);
    end
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] r, w;
    logic [63:0] pc;
    int lat, fl;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b1100111, 7'b0110111, 7'b1101111, 7'b1111111, 7'b0010111, 7'b0000000};
    RST = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc_in = '0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;
    model_reset();
    step();
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("rst_req",  64'(bus.imem_req), 64'(0));
    chk("rst_done", 64'(fetch_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    check_regs("rst");
    RST = 1'b0;
    step();

    fetch("zero_lat", 64'h40,  32'h00A28293, 0, -1, 1'b0);
    fetch("bne_lat3", 64'h100, 32'h00B51463, 3, -1, 1'b0);
    fetch("misalign", 64'h42,  32'h0,        0, -1, 1'b0);
    fetch("timeout",  64'h80,  32'hDEADBEEF, 7, -1, 1'b1);
    fetch("flush_vld", 64'h200, 32'h12345033, 2, 2, 1'b1);
    fetch("flush_drn", 64'h300, 32'h00000537, 3, 1, 1'b0);
    fetch("lat_max",  64'h304, 32'h0080006F, TMO, -1, 1'b0);
    fetch("lat_over", 64'h308, 32'h00112023, TMO + 1, -1, 1'b0);
    fetch("jalr_sb",  64'h30C, 32'h000090E7, 1, -1, 1'b0);
    fetch("jalr_i",   64'h310, 32'h000080E7, 1, -1, 1'b0);

    // fetch_req together with flush in IDLE is dropped
    pc_in = 64'h400; fetch_req = 1'b1; flush = 1'b1;
    step();
    fetch_req = 1'b0; flush = 1'b0;
    chk("req_flush_req",  64'(bus.imem_req), 64'(0));
    chk("req_flush_busy", 64'(busy), 64'(0));
    chk("req_flush_done", 64'(fetch_done), 64'(0));
    check_regs("req_flush");

    // asynchronous reset while waiting on memory
    pc_in = 64'h500; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("arst_addr", bus.imem_addr, 64'h0);
    chk("arst_req",  64'(bus.imem_req), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(fetch_done), 64'(0));
    check_regs("arst");
    @(negedge CLK);
    RST = 1'b0;
    bus.imem_valid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    step();
    bus.imem_valid = 1'b0;
    chk("late_done", 64'(fetch_done), 64'(0));
    chk("late_busy", 64'(busy), 64'(0));
    check_regs("late");
    fetch("invalid", 64'h600, 32'h0000007F, 1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      w   = {r[31:7], ops[$urandom_range(0, 11)]};
      pc  = {32'h0, $urandom()};
      if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
      lat = $urandom_range(0, TMO + 2);
      fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TMO + 2) : -1;
      fetch("rand", pc, w, lat, fl, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage for the multicycle RISC-V core. It sits directly upstream of the control state machine. On request it reads one 32-bit instruction from instruction memory through a valid/latency handshake. It holds that instruction in the instruction register and drives it, together with its opcode and a registered instruction-class code, to the control FSM. It also handles misaligned PCs, memory timeouts, and branch-redirect flushes.

## Interface
- TIMEOUT, 15: max cycles waited for imem_valid after a request; minimum 1.
- RESET_IR, 32'h00000013: reset/error value of INSTRUCAO (addi x0,x0,0).
- CLK  in  1  clock, rising edge.
- RST  in  1  reset. Asynchronous and active-high.
- fetch_req  in  1  start a fetch at pc_in. Honoured only in IDLE.
- flush  in  1  abort an outstanding fetch.
- pc_in  in  64  fetch address from the PC register.
- imem_addr  out  64  registered copy of the accepted pc_in.
- imem_req  out  1  one-cycle request strobe to instruction memory.
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- imem_valid  in  1  response strobe; one per request.
- INSTRUCAO  out  32  instruction register.
- op_code  out  7  INSTRUCAO[6:0].
- tipo_op  out  3  registered class: R=0, I=1, S=2, SB=3, U=4, UJ=5, INVALID=7.
- fetch_done  out  1  one-cycle pulse when INSTRUCAO/tipo_op have been updated.
- busy  out  1  high in every state except IDLE.
- fetch_err  out  2  sticky until next accepted fetch: 00 ok, 01 misaligned, 10 timeout.

## Operation
- States: IDLE, WAIT, DRAIN.
- Reset values:
  - State: IDLE.
  - INSTRUCAO: RESET_IR. op_code: 7'h13. tipo_op: I.
  - imem_addr: 0. imem_req, fetch_done, busy: 0. fetch_err: 00. Timeout counter: 0.
- IDLE, fetch_req=1, flush=0:
  - If pc_in[1:0]≠00: no memory request. INSTRUCAO←RESET_IR, tipo_op←I, fetch_err←01, fetch_done pulses, stay IDLE.
  - Otherwise: imem_addr←pc_in, imem_req=1 for exactly the next cycle, counter←0, fetch_err←00, go to WAIT.
- WAIT:
  - imem_valid=1 and flush=0: INSTRUCAO←imem_rdata, tipo_op←class(imem_rdata), fetch_done pulses, go to IDLE.
  - imem_valid=0: counter increments. When counter reaches TIMEOUT: INSTRUCAO←RESET_IR, tipo_op←I, fetch_err←10, fetch_done pulses, go to DRAIN.
  - flush=1: go to DRAIN if imem_valid=0. If imem_valid=1 in the same cycle, flush wins: the data is discarded and the block goes to IDLE. No fetch_done pulse.
- DRAIN: wait for imem_valid, discard the data, go to IDLE. fetch_req is ignored.
- fetch_req while busy: ignored, not queued.
- flush in IDLE: no effect. fetch_req and flush together in IDLE: the request is dropped.
- Class decode on opcode [6:0]:
  - 0110011 → R.
  - 0010011, 0000011, 1110011 → I.
  - 0100011 → S.
  - 1100011 → SB.
  - 1100111 → SB if funct3=001, else I.
  - 0110111 → U.
  - 1101111 → UJ.
  - Any other opcode → INVALID.
- INSTRUCAO, op_code and tipo_op change only on fetch_done, on the misaligned path, or on reset.
- Reset asserted mid-fetch returns the block to IDLE immediately. A late imem_valid after reset is ignored in IDLE.

## Timing
- Aligned fetch accepted at edge E0:
  - imem_req high in cycle E0–E1.
  - imem_valid may arrive in the same cycle at the earliest.
  - INSTRUCAO is loaded at E1 and fetch_done is high in cycle E1–E2.
  - Minimum latency from request to instruction: 1 edge; with memory latency L, L+1 edges.
- Misaligned fetch: fetch_done high in the cycle after the accepting edge.
- Timeout: fetch_done high in the cycle after the edge where counter=TIMEOUT, i.e. TIMEOUT+1 cycles after the request edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package riscv_pkg holds:
  - Opcode constants (OP_R=7'b0110011, OP_IMM, OP_LOAD, OP_SYS, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_JAL).
  - Enum tipo_op_t (codes above).
  - Constant NOP_INSTR=32'h00000013.
  - Enum fetch_err_t.
- One sub-module, decodifica_tipo: purely combinational opcode/funct3 → tipo_op_t. It is reused by the control FSM to replace its in-line class decode.

## Test plan
- Aligned fetch, zero latency: pc_in=64'h40, memory returns 32'h00A28293 in the request cycle → imem_addr=64'h40, INSTRUCAO=32'h00A28293, tipo_op=I, fetch_done one cycle later, fetch_err=00.
- Latency 3 with bne: imem_rdata=32'h00B51463 → tipo_op=SB, busy high for 4 cycles, one fetch_done pulse.
- Misaligned: pc_in=64'h42 → no imem_req, INSTRUCAO=32'h00000013, fetch_err=01, fetch_done next cycle.
- Timeout with TIMEOUT=4 and a silent memory: fetch_done 5 cycles after the request with fetch_err=10, state DRAIN. A late valid with 32'hDEADBEEF is discarded and INSTRUCAO stays 32'h00000013.
- Flush coinciding with imem_valid: INSTRUCAO unchanged, no fetch_done, IDLE next cycle. A fetch_req held high during WAIT issues no second imem_req.
- RST pulsed during WAIT: outputs return to their reset values asynchronously. A subsequent opcode 7'b1111111 fetch gives tipo_op=INVALID.
